// File: rtl/rv_sys_mon.sv
`default_nettype none
// ============================================================================
// Module   : rv_sys_mon
// Brief    : Local-bus system monitor. Captures on-die ADC slots into readable
//            registers and drives a software-controlled PWM fan output.
// Revision : 1.0 - initial release
// ============================================================================

// Idle model of the vendor system-monitor primitive; it holds its outputs
// at their reset values so the wrapper elaborates without the vendor library.
module rv_sys_mon_adc (
  input  logic        cclk,
  input  logic        reset_in,
  output logic [5:0]  channel_out,
  output logic        eoc_out,
  output logic [15:0] adc_data_master
);

  always_ff @(posedge cclk) begin
    if (reset_in) begin
      channel_out     <= '0;
      eoc_out         <= 1'b0;
      adc_data_master <= '0;
    end
  end

endmodule

module rv_sys_mon #(
  parameter int         PWM_DIV  = 16,
  parameter logic [7:0] DUTY_RST = 8'hFF
) (
  input  logic        cclk,
  input  logic        xreset,
  input  logic [4:0]  adr,
  input  logic        cs,
  input  logic        rdy,
  input  logic [3:0]  we,
  input  logic        re,
  input  logic [31:0] dw,
  output logic [31:0] dr,
  output logic        fan_out
);

  localparam int                 c_PRE_W   = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam logic [c_PRE_W-1:0] c_PRE_MAX = c_PRE_W'(PWM_DIV - 1);

  logic [5:0]         w_adc_ch;
  logic               w_adc_eoc;
  logic [15:0]        w_adc_data;
  logic               w_adc_reset;
  logic [2:0]         w_word;
  logic               w_rd_en;
  logic               w_wr_en;
  logic [31:0]        w_rd_data;
  logic               w_unused;

  logic [7:0]         r_duty;
  logic [c_PRE_W-1:0] r_pre;
  logic [7:0]         r_cnt;
  logic [15:0]        r_temp;
  logic [15:0]        r_vint;
  logic [15:0]        r_vaux;
  logic [15:0]        r_vbram;

  assign w_adc_reset = !xreset;
  assign w_word      = adr[4:2];
  assign w_rd_en     = cs & re & rdy;
  assign w_wr_en     = cs & we[0] & rdy & (w_word == 3'd0);
  assign w_unused    = ^{adr[1:0], we[3:1], dw[31:8]};

  rv_sys_mon_adc u_adc (
    .cclk            (cclk),
    .reset_in        (w_adc_reset),
    .channel_out     (w_adc_ch),
    .eoc_out         (w_adc_eoc),
    .adc_data_master (w_adc_data)
  );

  always_comb begin
    w_rd_data = '0;
    case (w_word)
      3'd0:    w_rd_data = {16'h0, r_temp};
      3'd1:    w_rd_data = {16'h0, r_vint};
      3'd2:    w_rd_data = {16'h0, r_vaux};
      3'd6:    w_rd_data = {16'h0, r_vbram};
      3'd7:    w_rd_data = {24'h0, r_duty};
      default: w_rd_data = '0;
    endcase
  end

  // Bus side: reads sample the pre-edge register values, so a same-cycle
  // slot capture or duty write is only visible on the following read.
  always_ff @(posedge cclk or negedge xreset) begin
    if (!xreset) begin
      r_duty <= DUTY_RST;
      dr     <= '0;
    end else begin
      if (w_wr_en) r_duty <= dw[7:0];
      if (w_rd_en) dr     <= w_rd_data;
    end
  end

  always_ff @(posedge cclk or negedge xreset) begin
    if (!xreset) begin
      r_temp  <= '0;
      r_vint  <= '0;
      r_vaux  <= '0;
      r_vbram <= '0;
    end else if (w_adc_eoc) begin
      case (w_adc_ch)
        6'd0:    r_temp  <= w_adc_data;
        6'd1:    r_vint  <= w_adc_data;
        6'd2:    r_vaux  <= w_adc_data;
        6'd6:    r_vbram <= w_adc_data;
        default: ;
      endcase
    end
  end

  // Free-running PWM; duty changes never restart the period.
  always_ff @(posedge cclk or negedge xreset) begin
    if (!xreset) begin
      r_pre   <= '0;
      r_cnt   <= '0;
      fan_out <= 1'b1;
    end else begin
      if (r_pre == c_PRE_MAX) begin
        r_pre <= '0;
        r_cnt <= r_cnt + 8'd1;
      end else begin
        r_pre <= r_pre + 1'b1;
      end
      fan_out <= (r_cnt < r_duty);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rv_sys_mon.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv_sys_mon
// Brief    : Directed bench for rv_sys_mon with a read-data scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv_sys_mon;

  logic        cclk = 1'b0;
  logic        xreset;
  logic [4:0]  adr;
  logic        cs, rdy, re;
  logic [3:0]  we;
  logic [31:0] dw;
  logic [31:0] dr;
  logic        fan_out;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] sb_q[$];

  rv_sys_mon #(.PWM_DIV(16), .DUTY_RST(8'hFF)) dut (
    .cclk    (cclk),
    .xreset  (xreset),
    .adr     (adr),
    .cs      (cs),
    .rdy     (rdy),
    .we      (we),
    .re      (re),
    .dw      (dw),
    .dr      (dr),
    .fan_out (fan_out)
  );

  always #5 cclk = ~cclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d,
                           input logic [3:0] w, input logic r);
    @(negedge cclk);
    adr = a; dw = d; we = w; cs = 1'b1; rdy = r;
    @(posedge cclk); #1;
    cs = 1'b0; we = 4'b0; rdy = 1'b1;
  endtask

  task automatic bus_read(input string tag, input logic [4:0] a, input logic [31:0] exp);
    @(negedge cclk);
    adr = a; cs = 1'b1; re = 1'b1; rdy = 1'b1;
    sb_q.push_back(exp);
    @(posedge cclk); #1;
    cs = 1'b0; re = 1'b0;
    check(tag, dr, sb_q.pop_front());
  endtask

  task automatic measure(input string tag, input int exp_high);
    int hi = 0;
    repeat (3) @(negedge cclk);
    for (int i = 0; i < 4096; i++) begin
      @(negedge cclk);
      if (fan_out === 1'b1) hi++;
    end
    check(tag, 32'(hi), 32'(exp_high));
  endtask

  task automatic adc_event(input logic [5:0] ch, input logic [15:0] d);
    @(negedge cclk);
    force dut.w_adc_ch   = ch;
    force dut.w_adc_data = d;
    force dut.w_adc_eoc  = 1'b1;
    @(posedge cclk); #1;
    force dut.w_adc_eoc  = 1'b0;
  endtask

  initial begin
    int waited;
    xreset = 1'b0; adr = '0; cs = 1'b0; rdy = 1'b1; we = '0; re = 1'b0; dw = '0;
    repeat (3) @(posedge cclk);
    #1;
    check("reset_fan", 32'(fan_out), 32'd1);
    check("reset_dr", dr, 32'h0);
    @(negedge cclk);
    xreset = 1'b1;

    measure("pwm_after_reset", 4080);
    bus_read("duty_reset", 5'h1C, 32'h0000_00FF);

    bus_write(5'h00, 32'h0000_0000, 4'b0001, 1'b1);
    measure("pwm_duty_00", 0);
    bus_write(5'h00, 32'h0000_0080, 4'b0001, 1'b1);
    measure("pwm_duty_80", 2048);
    bus_write(5'h00, 32'h0000_0001, 4'b0001, 1'b1);
    measure("pwm_duty_01", 16);
    bus_write(5'h00, 32'h0000_00FF, 4'b0001, 1'b1);
    measure("pwm_duty_ff", 4080);

    bus_write(5'h00, 32'h1234_5604, 4'b1111, 1'b1);
    bus_read("duty_full_word", 5'h1C, 32'h0000_0004);
    bus_write(5'h00, 32'h1234_56AA, 4'b1110, 1'b1);
    bus_read("duty_we0_clear", 5'h1C, 32'h0000_0004);
    bus_write(5'h1C, 32'h0000_0077, 4'b1111, 1'b1);
    bus_read("write_idx7_ignored", 5'h1C, 32'h0000_0004);
    bus_write(5'h03, 32'h0000_0055, 4'b1111, 1'b1);
    bus_read("adr_low_bits_ignored", 5'h1F, 32'h0000_0055);

    adc_event(6'd0, 16'hA5C0);
    adc_event(6'd1, 16'h5550);
    adc_event(6'd2, 16'h9990);
    adc_event(6'd6, 16'h5550);
    adc_event(6'd3, 16'h1234);
    bus_read("adc_temp", 5'h00, 32'h0000_A5C0);
    bus_read("adc_vint", 5'h04, 32'h0000_5550);
    bus_read("adc_vaux", 5'h08, 32'h0000_9990);
    bus_read("adc_vbram", 5'h18, 32'h0000_5550);
    bus_read("idx3_zero", 5'h0C, 32'h0000_0000);
    bus_read("idx4_zero", 5'h10, 32'h0000_0000);

    // Capture and read of the same slot on one edge returns the old value.
    force dut.w_adc_ch   = 6'd0;
    force dut.w_adc_data = 16'hBEEF;
    force dut.w_adc_eoc  = 1'b1;
    bus_read("same_cycle_old", 5'h00, 32'h0000_A5C0);
    force dut.w_adc_eoc  = 1'b0;
    bus_read("same_cycle_new", 5'h00, 32'h0000_BEEF);

    bus_write(5'h00, 32'h0000_0040, 4'b0001, 1'b0);
    bus_read("rdy_low_no_write", 5'h1C, 32'h0000_0055);
    bus_write(5'h00, 32'h0000_0040, 4'b0001, 1'b1);
    bus_read("rdy_high_write", 5'h1C, 32'h0000_0040);

    bus_write(5'h00, 32'h0000_0080, 4'b0001, 1'b1);
    waited = 0;
    repeat (3) @(negedge cclk);
    while (fan_out !== 1'b0 && waited < 5000) begin
      @(negedge cclk);
      waited++;
    end
    check("wait_fan_low", 32'(fan_out), 32'd0);
    #2;
    xreset = 1'b0;
    #1;
    check("async_reset_fan", 32'(fan_out), 32'd1);
    check("async_reset_dr", dr, 32'h0);
    @(negedge cclk);
    xreset = 1'b1;
    bus_read("duty_after_reset", 5'h1C, 32'h0000_00FF);
    bus_read("slot_after_reset", 5'h00, 32'h0000_0000);
    measure("pwm_after_reset2", 4080);

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
